// File: rtl/dest_ctrl_pkg.sv
// Shared encodings for the ALU destination shift-register controller.
package dest_ctrl_pkg;

   localparam int unsigned DEF_NUM_PASSES = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_LAST    = 2'd2,
      ST_WB_REQ  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DT_NONE = 2'b00,
      DT_VGPR = 2'b01,
      DT_SGPR = 2'b10,
      DT_EXEC = 2'b11
   } dest_type_t;

endpackage

// File: rtl/dest_pass_counter.sv
// Counts 16-lane result passes of one wavefront; wraps to 0 after the last pass.
module dest_pass_counter
   import dest_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PASSES = DEF_NUM_PASSES,
   localparam int unsigned CNT_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] pass_cnt,
   output logic             is_last
);

   assign is_last = (pass_cnt == CNT_W'(NUM_PASSES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass_cnt <= '0;
      end else if (clear) begin
         pass_cnt <= '0;
      end else if (inc) begin
         pass_cnt <= is_last ? '0 : pass_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dest_shift_ctrl.sv
// Sequences destination-buffer load/shift per ALU pass and issues the
// VGPR/SGPR writeback request once the wavefront result is complete.
module dest_shift_ctrl
   import dest_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PASSES = DEF_NUM_PASSES,
   parameter int unsigned WFID_W     = 6,
   parameter int unsigned VADDR_W    = 10,
   parameter int unsigned SADDR_W    = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               issue_valid,
   output logic               issue_ready,
   input  logic [WFID_W-1:0]  issue_wfid,
   input  logic [1:0]         issue_dest_type,
   input  logic [VADDR_W-1:0] issue_vgpr_addr,
   input  logic [SADDR_W-1:0] issue_sgpr_addr,
   input  logic               alu_pass_valid,
   output logic               alu_stall,
   output logic               dest_buffer_wr_en,
   output logic               dest_buffer_shift_en,
   output logic               vgpr_wr_req,
   output logic               sgpr_wr_req,
   output logic [VADDR_W-1:0] wb_vgpr_addr,
   output logic [SADDR_W-1:0] wb_sgpr_addr,
   output logic [WFID_W-1:0]  wb_wfid,
   output logic               wb_exec_sel,
   input  logic               wb_ack,
   output logic               instr_done,
   output logic               protocol_err
);

   localparam int unsigned CNT_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

   state_t           state;
   dest_type_t       lat_type;
   logic [CNT_W-1:0] pass_cnt;
   logic             is_last;
   logic             pass_inc;
   logic             cnt_clear;

   assign pass_inc  = (state == ST_COLLECT) && alu_pass_valid;
   assign cnt_clear = (state == ST_IDLE) && issue_valid;

   dest_pass_counter #(
      .NUM_PASSES(NUM_PASSES)
   ) u_pass_counter (
      .clk     (clk),
      .rst     (rst),
      .inc     (pass_inc),
      .clear   (cnt_clear),
      .pass_cnt(pass_cnt),
      .is_last (is_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                <= ST_IDLE;
         lat_type             <= DT_NONE;
         issue_ready          <= 1'b1;
         alu_stall            <= 1'b0;
         dest_buffer_wr_en    <= 1'b0;
         dest_buffer_shift_en <= 1'b0;
         vgpr_wr_req          <= 1'b0;
         sgpr_wr_req          <= 1'b0;
         wb_vgpr_addr         <= '0;
         wb_sgpr_addr         <= '0;
         wb_wfid              <= '0;
         wb_exec_sel          <= 1'b0;
         instr_done           <= 1'b0;
         protocol_err         <= 1'b0;
      end else begin
         dest_buffer_wr_en    <= 1'b0;
         dest_buffer_shift_en <= 1'b0;
         instr_done           <= 1'b0;

         // Passes are only meaningful in COLLECT; anywhere else they are dropped.
         if (alu_pass_valid && (state != ST_COLLECT)) begin
            protocol_err <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (issue_valid) begin
                  lat_type     <= dest_type_t'(issue_dest_type);
                  wb_vgpr_addr <= issue_vgpr_addr;
                  wb_sgpr_addr <= issue_sgpr_addr;
                  wb_wfid      <= issue_wfid;
                  issue_ready  <= 1'b0;
                  state        <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (alu_pass_valid) begin
                  dest_buffer_wr_en    <= 1'b1;
                  dest_buffer_shift_en <= (pass_cnt != '0);
                  if (is_last) begin
                     alu_stall <= 1'b1;
                     state     <= ST_LAST;
                  end
               end
            end
            ST_LAST: begin
               if (lat_type == DT_NONE) begin
                  alu_stall   <= 1'b0;
                  issue_ready <= 1'b1;
                  instr_done  <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  vgpr_wr_req <= (lat_type == DT_VGPR);
                  sgpr_wr_req <= (lat_type == DT_SGPR) || (lat_type == DT_EXEC);
                  wb_exec_sel <= (lat_type == DT_EXEC);
                  state       <= ST_WB_REQ;
               end
            end
            ST_WB_REQ: begin
               if (wb_ack) begin
                  vgpr_wr_req <= 1'b0;
                  sgpr_wr_req <= 1'b0;
                  wb_exec_sel <= 1'b0;
                  alu_stall   <= 1'b0;
                  issue_ready <= 1'b1;
                  instr_done  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
